// File: rtl/march_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : march_sequencer
//  Description : Steps the PMBIST address counter and memory strobes through
//                the hard-coded MATS+ or March C- element tables.
//  Revision    : 1.0 - initial release
// ============================================================================
module march_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter int                NUM_ADDR = 256,
    parameter int                ADMD_W   = 2,
    parameter logic [ADMD_W-1:0] ADMD_PR  = ADMD_W'(1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              cfg_alg,
    input  logic [ADMD_W-1:0] cfg_admd,
    input  logic              cfg_dbg,
    output logic [ADMD_W-1:0] cnt_admd,
    output logic              cnt_s,
    output logic              cnt_r,
    output logic              cnt_hold,
    output logic              cnt_updwn,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] exp_data,
    output logic [2:0]        elem_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_INIT = 2'd1;
    localparam logic [1:0] c_OP   = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [ADDR_W:0] c_LAST_LIN = (ADDR_W+1)'(NUM_ADDR - 1);
    localparam logic [ADDR_W:0] c_LAST_PR  = (ADDR_W+1)'(NUM_ADDR - 2);
    localparam logic [ADDR_W:0] c_ONE      = (ADDR_W+1)'(1);

    logic [1:0]        r_state;
    logic              r_alg;
    logic [ADMD_W-1:0] r_admd;
    logic              r_dbg;
    logic [2:0]        r_elem;
    logic              r_op_idx;
    logic [ADDR_W:0]   r_addr_cnt;

    logic              w_dir;
    logic              w_two_ops;
    logic              w_op0_wr;
    logic              w_op0_bit;
    logic              w_op1_wr;
    logic              w_op1_bit;
    logic              w_op_wr;
    logic              w_data_bit;
    logic              w_last_op;
    logic              w_last_elem;
    logic              w_final_addr;
    logic [ADDR_W:0]   w_last_addr;

    // Element table: direction, op count and the {write, bit} of each op.
    always_comb begin
        w_dir     = 1'b0;
        w_two_ops = 1'b0;
        w_op0_wr  = 1'b0;
        w_op0_bit = 1'b0;
        w_op1_wr  = 1'b0;
        w_op1_bit = 1'b0;
        if (!r_alg) begin
            case (r_elem)
                3'd0: begin
                    w_op0_wr = 1'b1;
                end
                3'd1: begin
                    w_two_ops = 1'b1;
                    w_op1_wr  = 1'b1;
                    w_op1_bit = 1'b1;
                end
                default: begin
                    w_dir     = 1'b1;
                    w_two_ops = 1'b1;
                    w_op0_bit = 1'b1;
                    w_op1_wr  = 1'b1;
                end
            endcase
        end else begin
            case (r_elem)
                3'd0: begin
                    w_op0_wr = 1'b1;
                end
                3'd1: begin
                    w_two_ops = 1'b1;
                    w_op1_wr  = 1'b1;
                    w_op1_bit = 1'b1;
                end
                3'd2: begin
                    w_two_ops = 1'b1;
                    w_op0_bit = 1'b1;
                    w_op1_wr  = 1'b1;
                end
                3'd3: begin
                    w_dir     = 1'b1;
                    w_two_ops = 1'b1;
                    w_op1_wr  = 1'b1;
                    w_op1_bit = 1'b1;
                end
                3'd4: begin
                    w_dir     = 1'b1;
                    w_two_ops = 1'b1;
                    w_op0_bit = 1'b1;
                    w_op1_wr  = 1'b1;
                end
                default: begin
                    w_op0_wr = 1'b0;
                end
            endcase
        end
    end

    assign w_op_wr      = r_op_idx ? w_op1_wr  : w_op0_wr;
    assign w_data_bit   = (r_op_idx ? w_op1_bit : w_op0_bit) ^ r_dbg;
    assign w_last_op    = !w_two_ops || r_op_idx;
    assign w_last_elem  = r_alg ? (r_elem == 3'd5) : (r_elem == 3'd2);
    // The LFSR never visits the all-zero state, so PR elements are one shorter.
    assign w_last_addr  = (r_admd == ADMD_PR) ? c_LAST_PR : c_LAST_LIN;
    assign w_final_addr = (r_addr_cnt == w_last_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_alg      <= 1'b0;
            r_admd     <= '0;
            r_dbg      <= 1'b0;
            r_elem     <= 3'd0;
            r_op_idx   <= 1'b0;
            r_addr_cnt <= '0;
        end else if (abort) begin
            r_state    <= c_IDLE;
            r_elem     <= 3'd0;
            r_op_idx   <= 1'b0;
            r_addr_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_alg   <= cfg_alg;
                        r_admd  <= cfg_admd;
                        r_dbg   <= cfg_dbg;
                        r_elem  <= 3'd0;
                        r_state <= c_INIT;
                    end
                end
                c_INIT: begin
                    r_addr_cnt <= '0;
                    r_op_idx   <= 1'b0;
                    r_state    <= c_OP;
                end
                c_OP: begin
                    if (w_last_op) begin
                        r_op_idx <= 1'b0;
                        if (w_final_addr) begin
                            if (w_last_elem) begin
                                r_state <= c_DONE;
                            end else begin
                                r_elem  <= r_elem + 3'd1;
                                r_state <= c_INIT;
                            end
                        end else begin
                            r_addr_cnt <= r_addr_cnt + c_ONE;
                        end
                    end else begin
                        r_op_idx <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state == c_INIT) || (r_state == c_OP);
    assign done      = (r_state == c_DONE);
    assign cnt_admd  = r_admd;
    assign cnt_s     = (r_state == c_INIT) && !w_dir;
    assign cnt_r     = (r_state == c_INIT) && w_dir;
    assign cnt_updwn = busy && w_dir;
    assign elem_idx  = r_elem;
    assign mem_we    = (r_state == c_OP) && w_op_wr;
    assign mem_re    = (r_state == c_OP) && !w_op_wr;
    assign mem_wdata = mem_we ? {DATA_W{w_data_bit}} : '0;
    assign exp_data  = mem_re ? {DATA_W{w_data_bit}} : '0;

    // The counter only steps on the edge that closes a non-final address.
    always_comb begin
        cnt_hold = 1'b1;
        if (r_state == c_INIT) begin
            cnt_hold = 1'b0;
        end else if (r_state == c_OP) begin
            cnt_hold = !(w_last_op && !w_final_addr);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_march_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_march_sequencer
//  Description : Scoreboard bench for march_sequencer with a table-driven
//                March model and randomized configuration / disturbances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_march_sequencer;

    localparam int              ADDR_W   = 8;
    localparam int              DATA_W   = 8;
    localparam int              NUM_ADDR = 256;
    localparam int              ADMD_W   = 2;
    localparam logic [ADMD_W-1:0] ADMD_PR = 2'd1;
    localparam logic [28:0]     c_RST_OUTS = 29'h100_0000;

    logic              clk = 1'b0;
    logic              rst, start, abort, cfg_alg, cfg_dbg;
    logic [ADMD_W-1:0] cfg_admd;
    logic [ADMD_W-1:0] cnt_admd;
    logic              cnt_s, cnt_r, cnt_hold, cnt_updwn, mem_we, mem_re, busy, done;
    logic [DATA_W-1:0] mem_wdata, exp_data;
    logic [2:0]        elem_idx;

    always #5 clk = ~clk;

    march_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_ADDR(NUM_ADDR),
        .ADMD_W(ADMD_W), .ADMD_PR(ADMD_PR)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_alg(cfg_alg), .cfg_admd(cfg_admd), .cfg_dbg(cfg_dbg),
        .cnt_admd(cnt_admd), .cnt_s(cnt_s), .cnt_r(cnt_r), .cnt_hold(cnt_hold),
        .cnt_updwn(cnt_updwn), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .exp_data(exp_data), .elem_idx(elem_idx),
        .busy(busy), .done(done)
    );

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] data;
        logic [2:0]        elem;
        logic              updwn;
        logic              hold;
        logic [ADMD_W-1:0] admd;
    } op_t;

    op_t sb_q[$];
    int  checks = 0;
    int  errors = 0;
    int  busy_cnt = 0, done_cnt = 0, s_cnt = 0, r_cnt = 0;

    int  m_nel;
    bit  m_dir[6];
    int  m_nops[6];
    bit  m_wr[6][2];
    bit  m_bit[6][2];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [28:0] outs();
        return {busy, done, cnt_s, cnt_r, cnt_hold, cnt_updwn, mem_we, mem_re,
                mem_wdata, exp_data, elem_idx, cnt_admd};
    endfunction

    function automatic void set_el(int e, bit d, int n, bit w0, bit b0, bit w1, bit b1);
        m_dir[e] = d; m_nops[e] = n;
        m_wr[e][0] = w0; m_bit[e][0] = b0;
        m_wr[e][1] = w1; m_bit[e][1] = b1;
    endfunction

    // Element lists written straight from the algorithm notation.
    function automatic void load_alg(bit alg);
        if (!alg) begin
            m_nel = 3;
            set_el(0, 0, 1, 1, 0, 0, 0);  // (w0)
            set_el(1, 0, 2, 0, 0, 1, 1);  // up (r0,w1)
            set_el(2, 1, 2, 0, 1, 1, 0);  // down (r1,w0)
        end else begin
            m_nel = 6;
            set_el(0, 0, 1, 1, 0, 0, 0);
            set_el(1, 0, 2, 0, 0, 1, 1);
            set_el(2, 0, 2, 0, 1, 1, 0);
            set_el(3, 1, 2, 0, 0, 1, 1);
            set_el(4, 1, 2, 0, 1, 1, 0);
            set_el(5, 0, 1, 0, 0, 0, 0);
        end
    endfunction

    task automatic push_model(input bit alg, input logic [ADMD_W-1:0] admd, input bit dbg,
                              output int exp_busy, output int n_s, output int n_r);
        int  len;
        op_t e;
        load_alg(alg);
        len = (admd == ADMD_PR) ? NUM_ADDR - 1 : NUM_ADDR;
        exp_busy = m_nel;
        n_s = 0;
        n_r = 0;
        for (int el = 0; el < m_nel; el++) begin
            if (m_dir[el]) n_r++; else n_s++;
            for (int a = 0; a < len; a++) begin
                for (int o = 0; o < m_nops[el]; o++) begin
                    e.we    = m_wr[el][o];
                    e.data  = {DATA_W{m_bit[el][o] ^ dbg}};
                    e.elem  = 3'(el);
                    e.updwn = m_dir[el];
                    e.hold  = !((o == m_nops[el] - 1) && (a != len - 1));
                    e.admd  = admd;
                    sb_q.push_back(e);
                    exp_busy++;
                end
            end
        end
    endtask

    // Monitor: counts activity and scores every memory op against the queue.
    initial begin
        op_t act, ex;
        forever begin
            @(negedge clk);
            if (busy)  busy_cnt++;
            if (done)  done_cnt++;
            if (cnt_s) s_cnt++;
            if (cnt_r) r_cnt++;
            if (cnt_s && cnt_r) chk("s_r_exclusive", 64'({cnt_s, cnt_r}), 64'(2'b10));
            if (mem_we && mem_re) chk("we_re_exclusive", 64'({mem_we, mem_re}), 64'(2'b10));
            if (mem_we || mem_re) begin
                if ((cnt_s || cnt_r) || !busy)
                    chk("strobe_outside_op", 64'({busy, cnt_s, cnt_r}), 64'(3'b100));
                act.we    = mem_we;
                act.data  = mem_we ? mem_wdata : exp_data;
                act.elem  = elem_idx;
                act.updwn = cnt_updwn;
                act.hold  = cnt_hold;
                act.admd  = cnt_admd;
                if (sb_q.size() == 0) begin
                    chk("unexpected_op", 64'(act), 64'(0));
                end else begin
                    ex = sb_q.pop_front();
                    chk("op{we,data,elem,updwn,hold,admd}", 64'(act), 64'(ex));
                end
            end
        end
    end

    task automatic pulse_start(input bit alg, input logic [ADMD_W-1:0] admd, input bit dbg);
        @(posedge clk); #1;
        start = 1'b1; cfg_alg = alg; cfg_admd = admd; cfg_dbg = dbg;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_rise", 64'(busy), 64'(1));
    endtask

    task automatic run_test(input bit alg, input logic [ADMD_W-1:0] admd, input bit dbg,
                            input bit poke);
        int exp_busy, n_s, n_r, b0, d0, s0, r0, k;
        bit seen;
        push_model(alg, admd, dbg, exp_busy, n_s, n_r);
        b0 = busy_cnt; d0 = done_cnt; s0 = s_cnt; r0 = r_cnt;
        pulse_start(alg, admd, dbg);
        k = poke ? int'($urandom_range(10, 200)) : -1;
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(posedge clk); #1;
            cfg_alg  = 1'($urandom);
            cfg_admd = ADMD_W'($urandom);
            cfg_dbg  = 1'($urandom);
            start    = (i == k);
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_seen", 64'(seen), 64'(1));
        chk("busy_cycles", 64'(busy_cnt - b0), 64'(exp_busy));
        chk("done_pulses", 64'(done_cnt - d0), 64'(1));
        chk("cnt_s_pulses", 64'(s_cnt - s0), 64'(n_s));
        chk("cnt_r_pulses", 64'(r_cnt - r0), 64'(n_r));
        chk("sb_leftover", 64'(sb_q.size()), 64'(0));
        sb_q.delete();
    endtask

    initial begin
        int  eb, ns, nr, d0;
        bit  hit;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_alg = 1'b0; cfg_admd = '0; cfg_dbg = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 64'(outs()), 64'(c_RST_OUTS));
        @(posedge clk); #1;
        rst = 1'b0;

        run_test(1'b0, 2'd0, 1'b0, 1'b0);
        run_test(1'b1, 2'd0, 1'b1, 1'b0);
        run_test(1'b0, ADMD_PR, 1'($urandom), 1'b0);
        run_test(1'b1, 2'd3, 1'($urandom), 1'b1);
        run_test(1'b1, ADMD_PR, 1'b0, 1'b1);

        // Abort part-way through element 2.
        push_model(1'b0, 2'd0, 1'b0, eb, ns, nr);
        d0 = done_cnt;
        pulse_start(1'b0, 2'd0, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (elem_idx == 3'd2) hit = 1'b1;
        end
        chk("reach_elem2", 64'(hit), 64'(1));
        repeat ($urandom_range(3, 200)) @(posedge clk);
        #1; abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("abort_idle", 64'({busy, done, mem_we, mem_re, cnt_s, cnt_r}), 64'(0));
        repeat (5) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - d0), 64'(0));
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_abort_idle", 64'(busy), 64'(0));
        run_test(1'b0, 2'd2, 1'b1, 1'b0);

        // Reset in the middle of a March C- run.
        push_model(1'b1, 2'd3, 1'b1, eb, ns, nr);
        pulse_start(1'b1, 2'd3, 1'b1);
        repeat ($urandom_range(50, 1000)) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        sb_q.delete();
        @(negedge clk);
        chk("mid_test_reset", 64'(outs()), 64'(c_RST_OUTS));
        @(posedge clk); #1;
        rst = 1'b0;
        run_test(1'b0, 2'd0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/march_sequencer.md
Name: march_sequencer

Overview:
- Sequences the PMBIST address counter and memory operations through a hard-coded March algorithm.
- Per element: drives the counter's set-first / set-last / hold / up-down / mode controls, then issues the element's read/write op list at every address.
- Sits between the BIST top-level control (start/abort/config) and the address counter plus memory-interface/comparator.

Parameters:
- ADDR_W, 8, address width; must match the address counter width.
- DATA_W, 8, memory data width; write and expected data are the per-op bit replicated.
- NUM_ADDR, 256, addresses visited per element in linear and address-complement modes.
- ADMD_W, 2, width of the address-mode code.
- ADMD_PR, 2'd1, mode code for the pseudo-random (LFSR) mode.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request to begin a test; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE
- cfg_alg  in  1  algorithm: 0 = MATS+, 1 = March C-
- cfg_admd  in  ADMD_W  address mode; latched on start
- cfg_dbg  in  1  data background; XORed into all data
- cnt_admd  out  ADMD_W  mode to the address counter
- cnt_s  out  1  set counter to first address
- cnt_r  out  1  set counter to last address
- cnt_hold  out  1  hold counter address
- cnt_updwn  out  1  direction: 0 = up/forward, 1 = down/reverse
- mem_we  out  1  write strobe for the current address
- mem_re  out  1  read strobe for the current address
- mem_wdata  out  DATA_W  write data
- exp_data  out  DATA_W  expected read data; valid when mem_re = 1
- elem_idx  out  3  index of the current March element
- busy  out  1  test in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst = 1 at posedge clk):
  - State becomes IDLE.
  - All outputs go to 0, except cnt_hold = 1 and cnt_admd = 0.
  - Internal op/address/element counters clear.
  - Reset wins over all other inputs, including mid-test.
- Element tables. ⇕ executes as ⇑. Ops are r0/r1/w0/w1; the op bit is XORed with the latched cfg_dbg.
  - MATS+ (3 elements): ⇕(w0); ⇑(r0,w1); ⇓(r1,w0).
  - March C- (6 elements): ⇕(w0); ⇑(r0,w1); ⇑(r1,w0); ⇓(r0,w1); ⇓(r1,w0); ⇕(r0).
- Element length: addresses per element = NUM_ADDR, or NUM_ADDR-1 when the latched mode is ADMD_PR (LFSR skips the all-zero state).
- IDLE:
  - busy = 0, cnt_hold = 1.
  - On start = 1: latch cfg_alg, cfg_admd and cfg_dbg; set elem_idx = 0; go to INIT.
- INIT (exactly 1 cycle; busy = 1, cnt_hold = 0):
  - ⇑ element: cnt_s = 1, cnt_updwn = 0.
  - ⇓ element: cnt_r = 1, cnt_updwn = 1.
  - Clear addr_cnt and op_idx; go to OP. The counter output holds the first address from the next cycle.
- OP (one op per cycle):
  - mem_we or mem_re asserts for the current op.
  - mem_wdata / exp_data = {DATA_W{op_bit ^ dbg}}.
  - cnt_hold = 1, except on the last op of an address that is not the element's final address; there cnt_hold = 0, so the counter steps on that edge.
  - Last op of an address: addr_cnt += 1 and op_idx resets.
  - Last op of the final address with more elements remaining: elem_idx += 1, go to INIT.
  - Last op of the final address on the final element: go to DONE.
- DONE: busy = 0, done = 1 for one cycle, then IDLE.
- Latency:
  - busy rises the cycle after start is sampled.
  - Total busy cycles = elements + addresses × Σ(ops per element).
- Boundary and corner cases:
  - start while not IDLE is ignored.
  - abort in any state: IDLE next cycle, no done pulse. If start and abort are both high in IDLE, abort wins and start is dropped.
  - cfg_* changes mid-test have no effect.
  - cnt_s and cnt_r are never asserted together and only in INIT.
  - mem_we and mem_re are never asserted together and never outside OP.
  - Address count compares against NUM_ADDR-1 (or NUM_ADDR-2 in PR mode) without overflow; addr_cnt is ADDR_W+1 bits wide.

Test Plan:
- MATS+, linear mode, dbg = 0, start pulse:
  - busy high 3 + 256×5 = 1283 cycles, then a single done pulse.
  - 256 w0, 256 r0 / 256 w1, then 256 r1 / 256 w0 with cnt_updwn = 1.
  - cnt_s asserts in INIT of elements 0 and 1; cnt_r in INIT of element 2.
- March C-, linear mode, dbg = 1:
  - busy 6 + 256×10 = 2566 cycles.
  - Element-1 reads carry exp_data = 8'hFF and writes carry mem_wdata = 8'h00 (background inverted).
  - elem_idx steps 0..5.
- PR mode, MATS+: addresses per element = 255; busy 3 + 255×5 = 1278 cycles; cnt_admd equals the latched mode throughout.
- Hold check: in a 2-op element, cnt_hold = 1 on op 0 and 0 on op 1 for each address, except the final address, which stays held.
- abort asserted mid element 2, then start re-issued:
  - Next cycle all strobes = 0, busy = 0, no done pulse.
  - The re-issued start begins at elem_idx = 0.
- rst asserted mid-test, and start pulsed while busy:
  - rst: all outputs return to their reset values on the next edge.
  - start while busy: no effect on sequence or cycle count.
